// File: rtl/tbus_arbiter_pkg.sv
// Types and helpers shared by the TBUS load/store arbiter and its grant picker.
`ifndef TBUS_DEFINES_SV
`include "defines.sv"
`endif

package tbus_arbiter_pkg;

   localparam int TBUS_W = 64;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [TBUS_W-1:0]         index;
      logic [TBUS_W-1:0]         write_data;
      logic [TBUS_W-1:0]         write_mask;
      logic [`TBUS_OPTYPE_RANGE] operation_type;
   } tbus_req_t;

   // The starvation counter is 3 bits wide, so larger limits behave as 7.
   function automatic logic [2:0] starve_limit_sat(input int limit);
      if (limit > 7)
         return 3'd7;
      else if (limit < 0)
         return 3'd0;
      else
         return 3'(limit);
   endfunction

endpackage

// File: rtl/defines.sv
// Shared TBUS encodings used by the load/store path and the dcache arbiter.
`ifndef TBUS_DEFINES_SV
`define TBUS_DEFINES_SV

`define TBUS_OPTYPE_RANGE 1:0
`define TBUS_READ         2'b00
`define TBUS_WRITE        2'b01

`define ARB_OWNER_LOAD    1'b0
`define ARB_OWNER_STORE   1'b1

`endif

// File: rtl/tbus_age_pick.sv
// Chooses between the load and store-queue requesters, letting loads win until
// the store queue has watched STARVE_LIMIT consecutive load grants go by.
`ifndef TBUS_DEFINES_SV
`include "defines.sv"
`endif

module tbus_age_pick
   import tbus_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic ld_valid,
   input  logic sq_valid,
   input  logic flush_valid,
   input  logic ld_fire,
   input  logic sq_fire,
   output logic sel_load,
   output logic sel_store
);

   localparam logic [2:0] LIMIT = starve_limit_sat(STARVE_LIMIT);

   logic [2:0] starve_cnt;
   logic       ld_eligible;

   // A flushed load is never a candidate, which hands the slot to the store queue.
   always_comb begin
      ld_eligible = ld_valid & ~flush_valid;
      sel_store   = sq_valid & (~ld_eligible | (starve_cnt >= LIMIT));
      sel_load    = ld_eligible & ~sel_store;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         starve_cnt <= 3'd0;
      else if (!sq_valid || sq_fire)
         starve_cnt <= 3'd0;
      else if (ld_fire && (starve_cnt != 3'd7))
         starve_cnt <= starve_cnt + 3'd1;
   end

endmodule

// File: rtl/tbus_arbiter.sv
// Arbitrates the load port and store-queue port onto a single dcache TBUS with
// one transaction outstanding; flushes kill only the response of a pending load.
`ifndef TBUS_DEFINES_SV
`include "defines.sv"
`endif

module tbus_arbiter
   import tbus_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clock,
   input  logic                      reset_n,

   input  logic                      ld2arb_tbus_index_valid,
   output logic                      ld2arb_tbus_index_ready,
   input  logic [63:0]               ld2arb_tbus_index,
   input  logic [63:0]               ld2arb_tbus_write_data,
   input  logic [63:0]               ld2arb_tbus_write_mask,
   input  logic [`TBUS_OPTYPE_RANGE] ld2arb_tbus_operation_type,
   output logic [63:0]               ld2arb_tbus_read_data,
   output logic                      ld2arb_tbus_operation_done,

   input  logic                      sq2arb_tbus_index_valid,
   output logic                      sq2arb_tbus_index_ready,
   input  logic [63:0]               sq2arb_tbus_index,
   input  logic [63:0]               sq2arb_tbus_write_data,
   input  logic [63:0]               sq2arb_tbus_write_mask,
   input  logic [`TBUS_OPTYPE_RANGE] sq2arb_tbus_operation_type,
   output logic [63:0]               sq2arb_tbus_read_data,
   output logic                      sq2arb_tbus_operation_done,

   output logic                      arb2dcache_tbus_index_valid,
   input  logic                      arb2dcache_tbus_index_ready,
   output logic [63:0]               arb2dcache_tbus_index,
   output logic [63:0]               arb2dcache_tbus_write_data,
   output logic [63:0]               arb2dcache_tbus_write_mask,
   output logic [`TBUS_OPTYPE_RANGE] arb2dcache_tbus_operation_type,
   input  logic [63:0]               arb2dcache_tbus_read_data,
   input  logic                      arb2dcache_tbus_operation_done,

   input  logic                      flush_valid
);

   arb_state_e state;
   arb_state_e state_next;
   logic       owner;
   logic       killed;
   logic       sel_load;
   logic       sel_store;
   logic       ld_fire;
   logic       sq_fire;
   logic       arb_fire;
   logic       grant_active;
   tbus_req_t  ld_req;
   tbus_req_t  sq_req;
   tbus_req_t  arb_req;

   assign ld_req   = {ld2arb_tbus_index, ld2arb_tbus_write_data,
                      ld2arb_tbus_write_mask, ld2arb_tbus_operation_type};
   assign sq_req   = {sq2arb_tbus_index, sq2arb_tbus_write_data,
                      sq2arb_tbus_write_mask, sq2arb_tbus_operation_type};
   assign ld_fire  = ld2arb_tbus_index_valid & ld2arb_tbus_index_ready;
   assign sq_fire  = sq2arb_tbus_index_valid & sq2arb_tbus_index_ready;
   assign arb_fire = arb2dcache_tbus_index_valid & arb2dcache_tbus_index_ready;

   tbus_age_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_age_pick (
      .clock       (clock),
      .reset_n     (reset_n),
      .ld_valid    (ld2arb_tbus_index_valid),
      .sq_valid    (sq2arb_tbus_index_valid),
      .flush_valid (flush_valid),
      .ld_fire     (ld_fire),
      .sq_fire     (sq_fire),
      .sel_load    (sel_load),
      .sel_store   (sel_store)
   );

   // Owner and kill flag travel with the FSM: captured at fire, cleared on completion.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ARB_IDLE;
         owner  <= `ARB_OWNER_LOAD;
         killed <= 1'b0;
      end else begin
         state <= state_next;
         if ((state == ARB_IDLE) && arb_fire) begin
            owner  <= sel_store ? `ARB_OWNER_STORE : `ARB_OWNER_LOAD;
            killed <= 1'b0;
         end else if (state == ARB_BUSY) begin
            if (arb2dcache_tbus_operation_done)
               killed <= 1'b0;
            else if (flush_valid && (owner == `ARB_OWNER_LOAD))
               killed <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ARB_IDLE: if (arb_fire) state_next = ARB_BUSY;
         ARB_BUSY: if (arb2dcache_tbus_operation_done) state_next = ARB_IDLE;
         default:  state_next = ARB_IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, even though requesters may be active.
   always_comb begin
      grant_active                = reset_n && (state == ARB_IDLE);
      arb_req                     = '0;
      arb2dcache_tbus_index_valid = 1'b0;
      ld2arb_tbus_index_ready     = 1'b0;
      sq2arb_tbus_index_ready     = 1'b0;
      ld2arb_tbus_operation_done  = 1'b0;
      ld2arb_tbus_read_data       = '0;
      sq2arb_tbus_operation_done  = 1'b0;
      sq2arb_tbus_read_data       = '0;

      if (grant_active && sel_store) begin
         arb_req                     = sq_req;
         arb2dcache_tbus_index_valid = 1'b1;
         sq2arb_tbus_index_ready     = arb2dcache_tbus_index_ready;
      end else if (grant_active && sel_load) begin
         arb_req                     = ld_req;
         arb2dcache_tbus_index_valid = 1'b1;
         ld2arb_tbus_index_ready     = arb2dcache_tbus_index_ready;
      end

      if (reset_n && (state == ARB_BUSY) && arb2dcache_tbus_operation_done) begin
         if (owner == `ARB_OWNER_STORE) begin
            sq2arb_tbus_operation_done = 1'b1;
            sq2arb_tbus_read_data      = arb2dcache_tbus_read_data;
         end else if (!killed && !flush_valid) begin
            ld2arb_tbus_operation_done = 1'b1;
            ld2arb_tbus_read_data      = arb2dcache_tbus_read_data;
         end
      end

      arb2dcache_tbus_index          = arb_req.index;
      arb2dcache_tbus_write_data     = arb_req.write_data;
      arb2dcache_tbus_write_mask     = arb_req.write_mask;
      arb2dcache_tbus_operation_type = arb_req.operation_type;
   end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Self-checking bench for tbus_arbiter: directed scenarios followed by random
// traffic compared against a transaction-level reference model.
module tb_tbus_arbiter;

   localparam int STARVE_LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;

   logic        ld2arb_tbus_index_valid;
   logic        ld2arb_tbus_index_ready;
   logic [63:0] ld2arb_tbus_index;
   logic [63:0] ld2arb_tbus_write_data;
   logic [63:0] ld2arb_tbus_write_mask;
   logic [1:0]  ld2arb_tbus_operation_type;
   logic [63:0] ld2arb_tbus_read_data;
   logic        ld2arb_tbus_operation_done;

   logic        sq2arb_tbus_index_valid;
   logic        sq2arb_tbus_index_ready;
   logic [63:0] sq2arb_tbus_index;
   logic [63:0] sq2arb_tbus_write_data;
   logic [63:0] sq2arb_tbus_write_mask;
   logic [1:0]  sq2arb_tbus_operation_type;
   logic [63:0] sq2arb_tbus_read_data;
   logic        sq2arb_tbus_operation_done;

   logic        arb2dcache_tbus_index_valid;
   logic        arb2dcache_tbus_index_ready;
   logic [63:0] arb2dcache_tbus_index;
   logic [63:0] arb2dcache_tbus_write_data;
   logic [63:0] arb2dcache_tbus_write_mask;
   logic [1:0]  arb2dcache_tbus_operation_type;
   logic [63:0] arb2dcache_tbus_read_data;
   logic        arb2dcache_tbus_operation_done;

   logic        flush_valid;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;

   always #5 clock = ~clock;

   tbus_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clock                          (clock),
      .reset_n                        (reset_n),
      .ld2arb_tbus_index_valid        (ld2arb_tbus_index_valid),
      .ld2arb_tbus_index_ready        (ld2arb_tbus_index_ready),
      .ld2arb_tbus_index              (ld2arb_tbus_index),
      .ld2arb_tbus_write_data         (ld2arb_tbus_write_data),
      .ld2arb_tbus_write_mask         (ld2arb_tbus_write_mask),
      .ld2arb_tbus_operation_type     (ld2arb_tbus_operation_type),
      .ld2arb_tbus_read_data          (ld2arb_tbus_read_data),
      .ld2arb_tbus_operation_done     (ld2arb_tbus_operation_done),
      .sq2arb_tbus_index_valid        (sq2arb_tbus_index_valid),
      .sq2arb_tbus_index_ready        (sq2arb_tbus_index_ready),
      .sq2arb_tbus_index              (sq2arb_tbus_index),
      .sq2arb_tbus_write_data         (sq2arb_tbus_write_data),
      .sq2arb_tbus_write_mask         (sq2arb_tbus_write_mask),
      .sq2arb_tbus_operation_type     (sq2arb_tbus_operation_type),
      .sq2arb_tbus_read_data          (sq2arb_tbus_read_data),
      .sq2arb_tbus_operation_done     (sq2arb_tbus_operation_done),
      .arb2dcache_tbus_index_valid    (arb2dcache_tbus_index_valid),
      .arb2dcache_tbus_index_ready    (arb2dcache_tbus_index_ready),
      .arb2dcache_tbus_index          (arb2dcache_tbus_index),
      .arb2dcache_tbus_write_data     (arb2dcache_tbus_write_data),
      .arb2dcache_tbus_write_mask     (arb2dcache_tbus_write_mask),
      .arb2dcache_tbus_operation_type (arb2dcache_tbus_operation_type),
      .arb2dcache_tbus_read_data      (arb2dcache_tbus_read_data),
      .arb2dcache_tbus_operation_done (arb2dcache_tbus_operation_done),
      .flush_valid                    (flush_valid)
   );

   task automatic clear_inputs();
      ld2arb_tbus_index_valid        = 1'b0;
      ld2arb_tbus_index              = '0;
      ld2arb_tbus_write_data         = '0;
      ld2arb_tbus_write_mask         = '0;
      ld2arb_tbus_operation_type     = OP_READ;
      sq2arb_tbus_index_valid        = 1'b0;
      sq2arb_tbus_index              = '0;
      sq2arb_tbus_write_data         = '0;
      sq2arb_tbus_write_mask         = '0;
      sq2arb_tbus_operation_type     = OP_WRITE;
      arb2dcache_tbus_index_ready    = 1'b0;
      arb2dcache_tbus_read_data      = '0;
      arb2dcache_tbus_operation_done = 1'b0;
      flush_valid                    = 1'b0;
   endtask

   // One quiet cycle so every test starts from IDLE with the store-age count cleared.
   task automatic idle_cycle();
      clear_inputs();
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      ld2arb_tbus_index_valid        = 1'b1;
      ld2arb_tbus_index              = {$urandom, $urandom};
      sq2arb_tbus_index_valid        = 1'b1;
      sq2arb_tbus_index              = {$urandom, $urandom};
      sq2arb_tbus_write_data         = {$urandom, $urandom};
      arb2dcache_tbus_index_ready    = 1'b1;
      arb2dcache_tbus_operation_done = 1'b1;
      arb2dcache_tbus_read_data      = {$urandom, $urandom};
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if ({arb2dcache_tbus_index_valid, arb2dcache_tbus_index, arb2dcache_tbus_write_data,
              arb2dcache_tbus_write_mask, arb2dcache_tbus_operation_type} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_arb_bus actual valid=%b index=%h expected all zero",
                     arb2dcache_tbus_index_valid, arb2dcache_tbus_index);
         end
         checks++;
         if ({ld2arb_tbus_index_ready, sq2arb_tbus_index_ready,
              ld2arb_tbus_operation_done, sq2arb_tbus_operation_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_handshake actual=%b expected=0000",
                     {ld2arb_tbus_index_ready, sq2arb_tbus_index_ready,
                      ld2arb_tbus_operation_done, sq2arb_tbus_operation_done});
         end
         checks++;
         if ({ld2arb_tbus_read_data, sq2arb_tbus_read_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_read_data actual ld=%h sq=%h expected 0",
                     ld2arb_tbus_read_data, sq2arb_tbus_read_data);
         end
         @(negedge clock);
      end
      clear_inputs();
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_lone_store();
      idle_cycle();
      sq2arb_tbus_index_valid     = 1'b1;
      sq2arb_tbus_index           = 64'h8000_1000;
      sq2arb_tbus_write_data      = 64'hDEAD_BEEF;
      sq2arb_tbus_write_mask      = 64'hFF;
      sq2arb_tbus_operation_type  = OP_WRITE;
      arb2dcache_tbus_index_ready = 1'b1;
      #1;
      checks++;
      if ({sq2arb_tbus_index_ready, ld2arb_tbus_index_ready, arb2dcache_tbus_index_valid} !== 3'b101) begin
         errors++;
         $display("[TB] FAIL store_c0_ready actual sq/ld/arb=%b expected=101",
                  {sq2arb_tbus_index_ready, ld2arb_tbus_index_ready, arb2dcache_tbus_index_valid});
      end
      checks++;
      if ({arb2dcache_tbus_index, arb2dcache_tbus_write_data, arb2dcache_tbus_write_mask,
           arb2dcache_tbus_operation_type} !== {64'h8000_1000, 64'hDEAD_BEEF, 64'hFF, OP_WRITE}) begin
         errors++;
         $display("[TB] FAIL store_c0_fields actual index=%h data=%h mask=%h op=%b expected 80001000/deadbeef/ff/01",
                  arb2dcache_tbus_index, arb2dcache_tbus_write_data,
                  arb2dcache_tbus_write_mask, arb2dcache_tbus_operation_type);
      end
      for (int c = 1; c <= 2; c++) begin
         @(negedge clock);
         #1;
         checks++;
         if ({arb2dcache_tbus_index_valid, sq2arb_tbus_index_ready, sq2arb_tbus_operation_done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL store_busy_c%0d actual valid/ready/done=%b expected=000", c,
                     {arb2dcache_tbus_index_valid, sq2arb_tbus_index_ready, sq2arb_tbus_operation_done});
         end
      end
      @(negedge clock);
      arb2dcache_tbus_operation_done = 1'b1;
      arb2dcache_tbus_read_data      = 64'h5A5A_0001;
      #1;
      checks++;
      if ({sq2arb_tbus_operation_done, ld2arb_tbus_operation_done, sq2arb_tbus_read_data, ld2arb_tbus_read_data}
          !== {1'b1, 1'b0, 64'h5A5A_0001, 64'h0}) begin
         errors++;
         $display("[TB] FAIL store_c3_done actual sq_done=%b ld_done=%b sq_rd=%h ld_rd=%h expected 1/0/5a5a0001/0",
                  sq2arb_tbus_operation_done, ld2arb_tbus_operation_done,
                  sq2arb_tbus_read_data, ld2arb_tbus_read_data);
      end
      @(negedge clock);
      arb2dcache_tbus_operation_done = 1'b0;
      arb2dcache_tbus_index_ready    = 1'b0;
      #1;
      checks++;
      if ({arb2dcache_tbus_index_valid, sq2arb_tbus_operation_done} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL store_c4_idle actual valid/done=%b expected=10",
                  {arb2dcache_tbus_index_valid, sq2arb_tbus_operation_done});
      end
      idle_cycle();
   endtask

   task automatic test_starvation();
      int  grants;
      int  skipped;
      bit  fired;
      bit  exp_store;
      idle_cycle();
      grants  = 0;
      skipped = 0;
      fired   = 1'b0;
      for (int c = 0; c < 40 && grants < 10; c++) begin
         ld2arb_tbus_index_valid        = 1'b1;
         ld2arb_tbus_index              = 64'h8000_3000 + 64'(c);
         sq2arb_tbus_index_valid        = 1'b1;
         sq2arb_tbus_index              = 64'h8000_4000 + 64'(c);
         arb2dcache_tbus_index_ready    = 1'b1;
         arb2dcache_tbus_operation_done = fired;
         arb2dcache_tbus_read_data      = 64'(c);
         #1;
         fired = 1'b0;
         if (ld2arb_tbus_index_ready || sq2arb_tbus_index_ready) begin
            exp_store = (skipped >= STARVE_LIMIT);
            checks++;
            if ({ld2arb_tbus_index_ready, sq2arb_tbus_index_ready} !== {~exp_store, exp_store}) begin
               errors++;
               $display("[TB] FAIL starve_grant%0d actual ld/sq=%b expected=%b", grants,
                        {ld2arb_tbus_index_ready, sq2arb_tbus_index_ready}, {~exp_store, exp_store});
            end
            skipped = exp_store ? 0 : ((skipped < 7) ? skipped + 1 : 7);
            grants++;
            fired = 1'b1;
         end
         @(negedge clock);
      end
      checks++;
      if (grants != 10) begin
         errors++;
         $display("[TB] FAIL starve_timeout actual grants=%0d expected=10", grants);
      end
      arb2dcache_tbus_operation_done = fired;
      ld2arb_tbus_index_valid        = 1'b0;
      sq2arb_tbus_index_valid        = 1'b0;
      @(negedge clock);
      idle_cycle();
   endtask

   task automatic test_flush_kill();
      idle_cycle();
      for (int pass = 0; pass < 3; pass++) begin
         // pass 0: flush during BUSY; pass 1: clean load; pass 2: flush coincident with done
         ld2arb_tbus_index_valid     = 1'b1;
         ld2arb_tbus_index           = 64'h8000_2000;
         ld2arb_tbus_operation_type  = OP_READ;
         arb2dcache_tbus_index_ready = 1'b1;
         #1;
         checks++;
         if (ld2arb_tbus_index_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL kill_p%0d_grant actual=%b expected=1", pass, ld2arb_tbus_index_ready);
         end
         @(negedge clock);
         ld2arb_tbus_index_valid = 1'b0;
         flush_valid             = (pass == 0);
         @(negedge clock);
         flush_valid                    = (pass == 2);
         arb2dcache_tbus_operation_done = 1'b1;
         arb2dcache_tbus_read_data      = 64'h1234 + 64'(pass);
         #1;
         checks++;
         if ({ld2arb_tbus_operation_done, ld2arb_tbus_read_data} !==
             ((pass == 1) ? {1'b1, 64'h1235} : {1'b0, 64'h0})) begin
            errors++;
            $display("[TB] FAIL kill_p%0d_done actual done=%b rd=%h expected done=%b",
                     pass, ld2arb_tbus_operation_done, ld2arb_tbus_read_data, (pass == 1));
         end
         @(negedge clock);
         flush_valid                    = 1'b0;
         arb2dcache_tbus_operation_done = 1'b0;
         arb2dcache_tbus_index_ready    = 1'b0;
         ld2arb_tbus_index_valid        = 1'b1;
         #1;
         checks++;
         if (arb2dcache_tbus_index_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL kill_p%0d_idle actual valid=%b expected=1", pass, arb2dcache_tbus_index_valid);
         end
         @(negedge clock);
      end
      idle_cycle();
   endtask

   task automatic test_flush_idle();
      idle_cycle();
      ld2arb_tbus_index_valid     = 1'b1;
      ld2arb_tbus_index           = 64'h8000_5000;
      sq2arb_tbus_index_valid     = 1'b1;
      sq2arb_tbus_index           = 64'h8000_6000;
      sq2arb_tbus_write_data      = 64'hCAFE;
      flush_valid                 = 1'b1;
      arb2dcache_tbus_index_ready = 1'b1;
      #1;
      checks++;
      if ({sq2arb_tbus_index_ready, ld2arb_tbus_index_ready, arb2dcache_tbus_index} !==
          {1'b1, 1'b0, 64'h8000_6000}) begin
         errors++;
         $display("[TB] FAIL flush_idle_grant actual sq/ld=%b index=%h expected 10 80006000",
                  {sq2arb_tbus_index_ready, ld2arb_tbus_index_ready}, arb2dcache_tbus_index);
      end
      @(negedge clock);
      ld2arb_tbus_index_valid = 1'b0;
      sq2arb_tbus_index_valid = 1'b0;
      @(negedge clock);
      arb2dcache_tbus_operation_done = 1'b1;
      arb2dcache_tbus_read_data      = 64'h77;
      #1;
      checks++;
      if ({sq2arb_tbus_operation_done, sq2arb_tbus_read_data} !== {1'b1, 64'h77}) begin
         errors++;
         $display("[TB] FAIL flush_store_done actual done=%b rd=%h expected 1/77",
                  sq2arb_tbus_operation_done, sq2arb_tbus_read_data);
      end
      @(negedge clock);
      idle_cycle();
   endtask

   task automatic test_backpressure();
      logic [63:0] idx;
      logic [63:0] dat;
      idle_cycle();
      idx = {$urandom, $urandom};
      dat = {$urandom, $urandom};
      sq2arb_tbus_index_valid = 1'b1;
      sq2arb_tbus_index       = idx;
      sq2arb_tbus_write_data  = dat;
      sq2arb_tbus_write_mask  = 64'h0F;
      for (int c = 1; c <= 6; c++) begin
         arb2dcache_tbus_index_ready = (c == 6);
         #1;
         checks++;
         if ({arb2dcache_tbus_index_valid, arb2dcache_tbus_index, arb2dcache_tbus_write_data,
              arb2dcache_tbus_write_mask, sq2arb_tbus_index_ready} !== {1'b1, idx, dat, 64'h0F, (c == 6)}) begin
            errors++;
            $display("[TB] FAIL bp_c%0d actual valid=%b index=%h ready=%b expected 1/%h/%b", c,
                     arb2dcache_tbus_index_valid, arb2dcache_tbus_index, sq2arb_tbus_index_ready, idx, (c == 6));
         end
         @(negedge clock);
      end
      sq2arb_tbus_index_valid        = 1'b0;
      arb2dcache_tbus_operation_done = 1'b1;
      arb2dcache_tbus_read_data      = 64'h99;
      #1;
      checks++;
      if (sq2arb_tbus_operation_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_done actual=%b expected=1", sq2arb_tbus_operation_done);
      end
      @(negedge clock);
      arb2dcache_tbus_read_data = 64'hBAD;
      #1;
      checks++;
      if ({ld2arb_tbus_operation_done, sq2arb_tbus_operation_done, ld2arb_tbus_read_data, sq2arb_tbus_read_data} !== '0) begin
         errors++;
         $display("[TB] FAIL bp_spurious_done actual ld=%b sq=%b expected 0/0",
                  ld2arb_tbus_operation_done, sq2arb_tbus_operation_done);
      end
      @(negedge clock);
      idle_cycle();
   endtask

   task automatic test_reset_busy();
      idle_cycle();
      ld2arb_tbus_index_valid     = 1'b1;
      ld2arb_tbus_index           = 64'h8000_7000;
      arb2dcache_tbus_index_ready = 1'b1;
      @(negedge clock);
      sq2arb_tbus_index_valid = 1'b1;
      #1;
      checks++;
      if (arb2dcache_tbus_index_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rbusy_busy actual valid=%b expected=0", arb2dcache_tbus_index_valid);
      end
      #2;
      reset_n                        = 1'b0;
      arb2dcache_tbus_operation_done = 1'b1;
      #1;
      checks++;
      if ({arb2dcache_tbus_index_valid, arb2dcache_tbus_index, ld2arb_tbus_index_ready, sq2arb_tbus_index_ready,
           ld2arb_tbus_operation_done, sq2arb_tbus_operation_done, ld2arb_tbus_read_data, sq2arb_tbus_read_data} !== '0) begin
         errors++;
         $display("[TB] FAIL rbusy_in_reset actual valid=%b ready=%b%b done=%b%b expected all zero",
                  arb2dcache_tbus_index_valid, ld2arb_tbus_index_ready, sq2arb_tbus_index_ready,
                  ld2arb_tbus_operation_done, sq2arb_tbus_operation_done);
      end
      @(negedge clock);
      @(negedge clock);
      ld2arb_tbus_index_valid = 1'b0;
      sq2arb_tbus_index_valid = 1'b0;
      reset_n                 = 1'b1;
      #1;
      checks++;
      if ({ld2arb_tbus_operation_done, sq2arb_tbus_operation_done} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL rbusy_after_release actual ld/sq done=%b expected=00",
                  {ld2arb_tbus_operation_done, sq2arb_tbus_operation_done});
      end
      @(negedge clock);
      idle_cycle();
   endtask

   // Reference model tracks one outstanding transaction and how many loads jumped a waiting store.
   task automatic test_random();
      bit          busy;
      bit          owner_store;
      bit          killed;
      int          skipped;
      bit          ld_ok;
      bit          pick_store;
      bit          pick_load;
      logic [194:0] exp_bus;
      logic [1:0]   exp_ready;
      logic [1:0]   exp_done;
      logic [127:0] exp_rd;
      idle_cycle();
      busy = 0; owner_store = 0; killed = 0; skipped = 0;
      for (int c = 0; c < 400; c++) begin
         ld2arb_tbus_index_valid        = ($urandom_range(0, 1) == 1);
         ld2arb_tbus_index              = {$urandom, $urandom};
         ld2arb_tbus_write_data         = {$urandom, $urandom};
         ld2arb_tbus_write_mask         = {$urandom, $urandom};
         ld2arb_tbus_operation_type     = 2'($urandom_range(0, 3));
         sq2arb_tbus_index_valid        = ($urandom_range(0, 3) != 0);
         sq2arb_tbus_index              = {$urandom, $urandom};
         sq2arb_tbus_write_data         = {$urandom, $urandom};
         sq2arb_tbus_write_mask         = {$urandom, $urandom};
         sq2arb_tbus_operation_type     = 2'($urandom_range(0, 3));
         flush_valid                    = ($urandom_range(0, 7) == 0);
         arb2dcache_tbus_index_ready    = ($urandom_range(0, 2) != 0);
         arb2dcache_tbus_operation_done = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         arb2dcache_tbus_read_data      = {$urandom, $urandom};
         #1;
         ld_ok      = ld2arb_tbus_index_valid && !flush_valid;
         pick_store = !busy && sq2arb_tbus_index_valid && (!ld_ok || skipped >= STARVE_LIMIT);
         pick_load  = !busy && !pick_store && ld_ok;
         exp_bus    = '0;
         if (pick_store)
            exp_bus = {1'b1, sq2arb_tbus_index, sq2arb_tbus_write_data, sq2arb_tbus_write_mask, sq2arb_tbus_operation_type};
         else if (pick_load)
            exp_bus = {1'b1, ld2arb_tbus_index, ld2arb_tbus_write_data, ld2arb_tbus_write_mask, ld2arb_tbus_operation_type};
         exp_ready = {pick_load && arb2dcache_tbus_index_ready, pick_store && arb2dcache_tbus_index_ready};
         exp_done  = {busy && arb2dcache_tbus_operation_done && !owner_store && !killed && !flush_valid,
                      busy && arb2dcache_tbus_operation_done && owner_store};
         exp_rd    = {exp_done[1] ? arb2dcache_tbus_read_data : 64'h0, exp_done[0] ? arb2dcache_tbus_read_data : 64'h0};

         checks++;
         if ({arb2dcache_tbus_index_valid, arb2dcache_tbus_index, arb2dcache_tbus_write_data,
              arb2dcache_tbus_write_mask, arb2dcache_tbus_operation_type} !== exp_bus) begin
            errors++;
            $display("[TB] FAIL rand_bus c=%0d actual valid=%b index=%h expected valid=%b index=%h", c,
                     arb2dcache_tbus_index_valid, arb2dcache_tbus_index, exp_bus[194], exp_bus[193:130]);
         end
         checks++;
         if ({ld2arb_tbus_index_ready, sq2arb_tbus_index_ready} !== exp_ready) begin
            errors++;
            $display("[TB] FAIL rand_ready c=%0d actual ld/sq=%b expected=%b", c,
                     {ld2arb_tbus_index_ready, sq2arb_tbus_index_ready}, exp_ready);
         end
         checks++;
         if ({ld2arb_tbus_operation_done, sq2arb_tbus_operation_done} !== exp_done) begin
            errors++;
            $display("[TB] FAIL rand_done c=%0d actual ld/sq=%b expected=%b", c,
                     {ld2arb_tbus_operation_done, sq2arb_tbus_operation_done}, exp_done);
         end
         checks++;
         if ({ld2arb_tbus_read_data, sq2arb_tbus_read_data} !== exp_rd) begin
            errors++;
            $display("[TB] FAIL rand_rdata c=%0d actual ld=%h sq=%h expected ld=%h sq=%h", c,
                     ld2arb_tbus_read_data, sq2arb_tbus_read_data, exp_rd[127:64], exp_rd[63:0]);
         end

         if (!busy) begin
            if (!sq2arb_tbus_index_valid || (pick_store && arb2dcache_tbus_index_ready))
               skipped = 0;
            else if (pick_load && arb2dcache_tbus_index_ready && skipped < 7)
               skipped++;
            if ((pick_store || pick_load) && arb2dcache_tbus_index_ready) begin
               busy        = 1;
               owner_store = pick_store;
               killed      = 0;
            end
         end else begin
            if (!sq2arb_tbus_index_valid)
               skipped = 0;
            if (arb2dcache_tbus_operation_done) begin
               busy   = 0;
               killed = 0;
            end else if (flush_valid && !owner_store) begin
               killed = 1;
            end
         end
         @(negedge clock);
      end
      idle_cycle();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_lone_store();
      test_starvation();
      test_flush_kill();
      test_flush_idle();
      test_backpressure();
      test_reset_busy();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tbus_arbiter.md
TBUS_ARBITER -- requirements
Module: tbus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive load grants tolerated while the store queue waits.
REQ-002 clock  input  1  core clock.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ld2arb_tbus_index_valid / ld2arb_tbus_index_ready  input/output  1  load request handshake.
REQ-005 ld2arb_tbus_index, ld2arb_tbus_write_data, ld2arb_tbus_write_mask  input  64 each  load address, data and mask.
REQ-006 ld2arb_tbus_operation_type  input  `TBUS_OPTYPE_RANGE  load op type.
REQ-007 ld2arb_tbus_read_data / ld2arb_tbus_operation_done  output  64/1  load response.
REQ-008 sq2arb_tbus_* (index_valid, index_ready, index, write_data, write_mask, operation_type, read_data, operation_done)  same widths and directions as the load port  store-queue port.
REQ-009 arb2dcache_tbus_index_valid  output  1;  arb2dcache_tbus_index_ready  input  1.
REQ-010 arb2dcache_tbus_index, arb2dcache_tbus_write_data, arb2dcache_tbus_write_mask  output  64 each;  arb2dcache_tbus_operation_type  output  `TBUS_OPTYPE_RANGE.
REQ-011 arb2dcache_tbus_read_data  input  64;  arb2dcache_tbus_operation_done  input  1.
REQ-012 flush_valid  input  1  redirect flush; kills load traffic only.

Function
REQ-013 FSM states IDLE and BUSY; at most one dcache transaction outstanding.
REQ-014 IDLE, selection order:
  - store when sq valid and (load not eligible, or starve_cnt >= STARVE_LIMIT);
  - otherwise load, when ld valid and flush_valid low;
  - a load is eligible only when ld valid and flush_valid low.
REQ-015 IDLE, drive-through:
  - arb2dcache_tbus_index_valid = selected requester's valid;
  - index, data, mask and op type are passed combinationally from the selected requester;
  - all fields are zero when nothing is selected.
REQ-016 Requester ready = state IDLE & selected & arb2dcache_tbus_index_ready; the unselected requester's ready is 0.
REQ-017 Fire (valid & ready to dcache) latches owner (LOAD/STORE) and moves to BUSY next cycle.
REQ-018 BUSY:
  - arb2dcache_tbus_index_valid = 0;
  - both requester readies are 0;
  - the FSM waits for arb2dcache_tbus_operation_done.
REQ-019 On done in BUSY:
  - the owner's operation_done is pulsed in the same cycle, with read_data passed combinationally;
  - the other port's done stays 0 and its read_data is 0;
  - the FSM returns to IDLE next cycle (no same-cycle regrant).
REQ-020 A done pulse received in IDLE is ignored.
REQ-021 Load kill:
  - flush_valid in BUSY with owner LOAD sets a killed flag;
  - a flush in the same cycle as done suppresses that done;
  - on done, ld2arb_tbus_operation_done is suppressed, the transaction completes normally and killed clears.
REQ-022 Store transactions are never killed by flush.
REQ-023 starve_cnt, 3-bit saturating:
  - +1 on each load fire while sq valid;
  - cleared on store fire and whenever sq valid is low;
  - holds otherwise.
REQ-024 Simultaneous ld and sq valid with starve_cnt < STARVE_LIMIT: load wins; at STARVE_LIMIT: store wins.
REQ-025 If a requester drops valid before fire, nothing is latched and the FSM stays IDLE.

Reset
REQ-026 Reset state:
  - state IDLE, owner LOAD, killed 0, starve_cnt 0;
  - all valid, ready and done outputs 0;
  - all data outputs 0.
REQ-027 Reset asserted while BUSY abandons the transaction; no done is forwarded after reset release.

Structure
REQ-028 `TBUS_READ, `TBUS_WRITE and `TBUS_OPTYPE_RANGE are taken from defines.sv; new `ARB_OWNER_LOAD/`ARB_OWNER_STORE constants are added there.
REQ-029 Selection plus starve_cnt live in one sub-module, tbus_age_pick; the FSM, owner/killed registers and response routing stay in tbus_arbiter.

Verification
REQ-030 Lone store, addr 0x80001000, data 0xDEADBEEF, mask 0xFF, dcache ready:
  - sq ready in cycle 0 and BUSY in cycle 1;
  - done in cycle 3 -> sq operation_done=1 in cycle 3 and IDLE in cycle 4.
REQ-031 Continuous load and store valid, done 1 cycle after each fire -> grants L,L,L,L,S,L…; starve_cnt is 0 after the store.
REQ-032 Load read of 0x80002000, flush_valid in the BUSY cycle, done with read_data 0x1234 -> ld operation_done stays 0, then IDLE, killed cleared.
REQ-033 flush_valid with both ld and sq valid in IDLE -> store granted, ld ready=0.
REQ-034 dcache ready=0 for 5 cycles with sq valid:
  - arb valid held and fields stable;
  - fire in cycle 6;
  - a spurious done in IDLE produces no output pulse.
REQ-035 reset_n low mid-BUSY, then done after release -> no done on either port; all outputs 0 during reset.
